// File: rtl/prll_bs_pkg.sv
// Shared types and widths for the parallel-bus round-robin arbiter.
package prll_bs_pkg;
  localparam int DEST_W = 8;
  localparam int DROP_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PUSH = 2'd2
  } state_e;
endpackage

// File: rtl/prll_bs_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from last_grant+1.
module prll_bs_rr_pick #(
  parameter int DRVRS = 9,
  parameter int IW    = $clog2(DRVRS)
) (
  input  logic [DRVRS-1:0] req,
  input  logic [IW-1:0]    last_grant,
  output logic [IW-1:0]    grant,
  output logic             valid
);
  int idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int k = 1; k <= DRVRS; k++) begin
      idx = (int'(last_grant) + k) % DRVRS;
      if (!valid && req[idx[IW-1:0]]) begin
        valid = 1'b1;
        grant = idx[IW-1:0];
      end
    end
  end
endmodule

// File: rtl/prll_bs_rr_arbiter.sv
// Shared-bus arbiter: IDLE -> POP -> PUSH per packet, round-robin over drivers.
// Define PRLL_BS_BROADCAST_EN to deliver BROADCAST-addressed packets to every driver but the source.
module prll_bs_rr_arbiter
  import prll_bs_pkg::*;
#(
  parameter int          DRVRS     = 9,
  parameter int          BITS      = 32,
  parameter logic [7:0]  BROADCAST = 8'hFF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DRVRS-1:0]       pndng,
  input  logic [DRVRS*BITS-1:0]  D_pop,
  output logic [DRVRS-1:0]       pop,
  output logic [DRVRS-1:0]       push,
  output logic [BITS-1:0]        D_push,
  output logic                   busy,
  output logic [DROP_W-1:0]      drop_cnt
);
  localparam int IW = $clog2(DRVRS);

  state_e                        state;
  logic [IW-1:0]                 grant_q, last_grant, pick_grant;
  logic                          pick_valid;
  logic [BITS-1:0]               bus_q;
  logic [DROP_W-1:0]             drop_cnt_q;
  logic [DRVRS-1:0][BITS-1:0]    slot;
  logic [DEST_W-1:0]             dest;
  logic [DRVRS-1:0]              src_oh, dst_oh;
  logic                          in_range, bcast, drop;

  assign slot     = D_pop;
  assign dest     = bus_q[BITS-1 -: DEST_W];
  assign in_range = (dest < DEST_W'(DRVRS));
  assign src_oh   = DRVRS'(1) << grant_q;
  assign dst_oh   = DRVRS'(1) << dest;

`ifdef PRLL_BS_BROADCAST_EN
  assign bcast = (dest == BROADCAST);
`else
  assign bcast = 1'b0;
`endif

  assign drop = (state == PUSH) && !bcast && !in_range;

  prll_bs_rr_pick #(.DRVRS(DRVRS), .IW(IW)) u_pick (
    .req        (pndng),
    .last_grant (last_grant),
    .grant      (pick_grant),
    .valid      (pick_valid)
  );

  // Push is suppressed while reset is high so an aborted transfer never reaches a FIFO.
  always_comb begin
    pop  = '0;
    push = '0;
    if (state == POP) pop = src_oh;
    if (state == PUSH && !reset) begin
      if (bcast)         push = ~src_oh;
      else if (in_range) push = dst_oh;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant_q    <= '0;
      last_grant <= IW'(DRVRS-1);
      bus_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      case (state)
        IDLE: if (pick_valid) begin
          grant_q <= pick_grant;
          state   <= POP;
        end
        POP: begin
          bus_q      <= slot[grant_q];
          last_grant <= grant_q;
          state      <= PUSH;
        end
        PUSH: begin
          if (drop && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign D_push   = bus_q;
  assign busy     = (state != IDLE);
  assign drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_prll_bs_rr_arbiter.sv
// Directed bench for prll_bs_rr_arbiter (DRVRS=9, BITS=32); honours PRLL_BS_BROADCAST_EN.
module tb_prll_bs_rr_arbiter;
  localparam int DRVRS = 9;
  localparam int BITS  = 32;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [DRVRS-1:0]      pndng;
  logic [DRVRS*BITS-1:0] D_pop;
  logic [DRVRS-1:0]      pop, push;
  logic [BITS-1:0]       D_push;
  logic                  busy;
  logic [15:0]           drop_cnt;

  int total = 0;
  int bad   = 0;
  int popcnt [DRVRS];

  always #5 clk = ~clk;

  prll_bs_rr_arbiter #(.DRVRS(DRVRS), .BITS(BITS), .BROADCAST(8'hFF)) dut (
    .clk      (clk),
    .reset    (reset),
    .pndng    (pndng),
    .D_pop    (D_pop),
    .pop      (pop),
    .push     (push),
    .D_push   (D_push),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_slot(input int i, input logic [7:0] dest, input logic [23:0] pl);
    D_pop[i*BITS +: BITS] = {dest, pl};
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    pndng = '0;
    D_pop = '0;
    step(); step();
    check("rst_pop",    32'(pop),      32'h0);
    check("rst_push",   32'(push),     32'h0);
    check("rst_dpush",  D_push,        32'h0);
    check("rst_busy",   32'(busy),     32'h0);
    check("rst_drop",   32'(drop_cnt), 32'h0);
    reset = 1'b0;

    // two packets to driver 2
    set_slot(0, 8'd2, 24'hA0A0A0);
    set_slot(1, 8'd2, 24'hA1A1A1);
    pndng = 9'h003;
    step(); check("t1_pop0",  32'(pop),  32'h001);
            check("t1_busy",  32'(busy), 32'h1);
            check("t1_nopush",32'(push), 32'h0);
    pndng = 9'h002;
    step(); check("t1_push0", 32'(push), 32'h004);
            check("t1_data0", D_push,    32'h02A0A0A0);
            check("t1_nopop", 32'(pop),  32'h0);
    step(); check("t1_idle",  32'(busy), 32'h0);
            check("t1_hold",  D_push,    32'h02A0A0A0);
            check("t1_idlepush", 32'(push), 32'h0);
    step(); check("t1_pop1",  32'(pop),  32'h002);
    pndng = '0;
    step(); check("t1_push1", 32'(push), 32'h004);
            check("t1_data1", D_push,    32'h02A1A1A1);
    step(); check("t1_done",  32'(busy), 32'h0);

    // all drivers pending, each addressed to itself
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < DRVRS; i++) begin
      set_slot(i, 8'(i), 24'h000100 + 24'(i));
      popcnt[i] = 0;
    end
    pndng = '1;
    for (int j = 0; j < 27; j++) begin
      step();
      for (int i = 0; i < DRVRS; i++) if (pop[i]) popcnt[i]++;
      check("t2_onehot", 32'($onehot0(pop)), 32'h1);
      check("t2_excl",   32'(|(pop & push)), 32'h0);
      if (j % 3 == 0) check("t2_pop", 32'(pop), 32'(1) << (j/3));
      if (j % 3 == 1) begin
        check("t2_push", 32'(push), 32'(1) << (j/3));
        check("t2_data", D_push, {8'(j/3), 24'h000100 + 24'(j/3)});
      end
      if (j == 26) pndng = '0;
    end
    for (int i = 0; i < DRVRS; i++) check("t2_popcnt", 32'(popcnt[i]), 32'h1);

    // out-of-range destination is dropped
    set_slot(4, 8'h0C, 24'h444444);
    pndng = 9'h010;
    step(); check("t3_pop",    32'(pop),      32'h010);
    pndng = '0;
    step(); check("t3_push",   32'(push),     32'h0);
            check("t3_drop0",  32'(drop_cnt), 32'h0);
    step(); check("t3_drop1",  32'(drop_cnt), 32'h1);

    // broadcast from driver 3
    set_slot(3, 8'hFF, 24'h333333);
    pndng = 9'h008;
    step(); check("t4_pop",   32'(pop), 32'h008);
    pndng = '0;
    step();
`ifdef PRLL_BS_BROADCAST_EN
    check("t4_push",  32'(push), 32'h1F7);
    check("t4_data",  D_push,    32'hFF333333);
    step(); check("t4_drop", 32'(drop_cnt), 32'h1);
`else
    check("t4_push",  32'(push), 32'h0);
    step(); check("t4_drop", 32'(drop_cnt), 32'h2);
`endif
    check("t4_after", 32'(push), 32'h0);

    // reset during PUSH aborts; next grant restarts from driver 0
    set_slot(6, 8'd5, 24'h666666);
    set_slot(7, 8'd3, 24'h777777);
    set_slot(2, 8'd1, 24'h222222);
    pndng = 9'h040;
    step(); check("t5_pop6", 32'(pop), 32'h040);
    pndng = 9'h084;
    step(); reset = 1'b1; #1;
            check("t5_nopush", 32'(push), 32'h0);
    step(); reset = 1'b0;
            check("t5_busy",  32'(busy),     32'h0);
            check("t5_drop",  32'(drop_cnt), 32'h0);
            check("t5_dpush", D_push,        32'h0);
            check("t5_push",  32'(push),     32'h0);
    step(); check("t5_pop2",  32'(pop),      32'h004);
    pndng = 9'h080;
    step(); check("t5_push1", 32'(push),     32'h002);
            check("t5_data",  D_push,        32'h01222222);
    pndng = '0;
    step(); check("t5_idle",  32'(busy),     32'h0);

    // saturation
    force dut.drop_cnt_q = 16'hFFFF;
    step();
    release dut.drop_cnt_q;
    check("t6_forced", 32'(drop_cnt), 32'hFFFF);
    set_slot(0, 8'h20, 24'h000000);
    pndng = 9'h001;
    step(); check("t6_pop", 32'(pop), 32'h001);
    pndng = '0;
    step(); check("t6_push", 32'(push), 32'h0);
    step(); check("t6_sat",  32'(drop_cnt), 32'hFFFF);
            check("t6_idle", 32'(busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
